// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 16-bit multiply (shift-add) and divide (restoring) sequencer.
// It borrows the shared combinational ALU for one iteration per granted cycle.
module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  input  logic             alu_gnt,
  output logic             alu_enable,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             op_r;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] rem_shift;

  // Divide shifts the next dividend bit into the partial remainder; hi[15] is the lost 17th bit.
  assign rem_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign res_hi     = hi;
  assign res_lo     = lo;
  assign alu_enable = (state == RUN);
  assign alu_sel    = op_r ? 4'b0001 : 4'b0000;
  assign alu_c_in   = 1'b0;
  assign alu_a      = (state != RUN) ? '0 : (op_r ? rem_shift : hi);
  assign alu_b      = (state != RUN) ? '0 : ((op_r || lo[0]) ? b : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= 1'b0;
      cnt      <= 4'd0;
      hi       <= '0;
      lo       <= '0;
      b        <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r     <= op;
            cnt      <= 4'd0;
            b        <= opb;
            div_zero <= 1'b0;
            if (op && (opb == '0)) begin
              div_zero <= 1'b1;
              hi       <= opa;
              lo       <= '1;
              state    <= DONE;
            end else begin
              hi    <= '0;
              lo    <= opa;
              state <= RUN;
            end
          end
        end
        RUN: begin
          // A withheld grant freezes everything while the ALU request stays up.
          if (alu_gnt) begin
            cnt <= cnt + 4'd1;
            if (!op_r) begin
              {hi, lo} <= {alu_c_out, alu_out, lo[WIDTH-1:1]};
            end else if (hi[WIDTH-1] || !alu_c_out) begin
              hi <= alu_out;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rem_shift;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
            if (cnt == 4'd15) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
